// File: rtl/gyro_integrate_sched.sv
// Time-shares one external signed divider across the three gyro axes and integrates
// the quotients into roll/pitch/yaw, publishing all three together with a ready pulse.
module gyro_integrate_sched #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DIVISOR = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk_100mhz,
  input  logic                    rst_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic signed [WIDTH-1:0] gx,
  input  logic signed [WIDTH-1:0] gy,
  input  logic signed [WIDTH-1:0] gz,
  input  logic                    zero_in,
  output logic                    div_start,
  output logic signed [WIDTH-1:0] div_a,
  output logic signed [WIDTH-1:0] div_b,
  input  logic                    div_done,
  input  logic signed [WIDTH-1:0] div_q,
  output logic signed [WIDTH-1:0] roll,
  output logic signed [WIDTH-1:0] pitch,
  output logic signed [WIDTH-1:0] yaw,
  output logic                    ready,
  output logic [7:0]              overrun_count,
  output logic                    div_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                  state_q;
  logic [1:0]              axis_q;
  logic [TW-1:0]           tmo_q;
  logic [2:0][WIDTH-1:0]   smp_q;
  logic [2:0][WIDTH-1:0]   acc_q;
  logic [2:0][WIDTH-1:0]   acc_d;
  logic [2:0][WIDTH-1:0]   ang_q;
  logic signed [WIDTH-1:0] div_a_q;
  logic signed [WIDTH-1:0] next_a;
  logic                    ready_q;
  logic                    div_err_q;
  logic [7:0]              ovr_q;
  logic                    timed_out;
  logic                    step;
  logic                    last_axis;

  always_comb begin
    timed_out = (state_q == StWait) && !div_done && (tmo_q == TW'(TIMEOUT - 1));
    step      = (state_q == StWait) && (div_done || timed_out);
    last_axis = (axis_q == 2'd2);
    acc_d     = acc_q;
    next_a    = div_a_q;
    for (int i = 0; i < 3; i++) begin
      // A timed-out axis contributes nothing, so only a real quotient is added.
      if (step && div_done && (axis_q == 2'(i))) acc_d[i] = acc_q[i] + div_q;
      if ((axis_q + 2'd1) == 2'(i)) next_a = smp_q[i];
    end
    if (zero_in) acc_d = '0;
  end

  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      axis_q    <= 2'd0;
      tmo_q     <= '0;
      smp_q     <= '0;
      acc_q     <= '0;
      ang_q     <= '0;
      div_a_q   <= '0;
      ready_q   <= 1'b0;
      div_err_q <= 1'b0;
      ovr_q     <= 8'd0;
    end else begin
      acc_q   <= acc_d;
      ready_q <= 1'b0;
      if (sample_valid && (state_q != StIdle) && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
      if (zero_in) ang_q <= '0;
      case (state_q)
        StIdle: begin
          if (sample_valid) begin
            smp_q   <= {gz, gy, gx};
            axis_q  <= 2'd0;
            div_a_q <= gx;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          tmo_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (step) begin
            if (timed_out) div_err_q <= 1'b1;
            if (last_axis) begin
              state_q <= StDone;
              ready_q <= 1'b1;
              if (!zero_in) ang_q <= acc_d;
            end else begin
              axis_q  <= axis_q + 2'd1;
              div_a_q <= next_a;
              state_q <= StIssue;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sample_ready  = (state_q == StIdle);
  assign div_start     = (state_q == StIssue);
  assign div_a         = div_a_q;
  assign div_b         = WIDTH'(DIVISOR);
  assign roll          = ang_q[0];
  assign pitch         = ang_q[1];
  assign yaw           = ang_q[2];
  assign ready         = ready_q;
  assign overrun_count = ovr_q;
  assign div_err       = div_err_q;

endmodule

// File: tb/tb_gyro_integrate_sched.sv
// Scoreboard bench for gyro_integrate_sched: a behavioural divider, a sample-level
// reference model feeding an expectation queue, and a monitor checking each ready pulse.
module tb_gyro_integrate_sched;

  logic               clk_100mhz = 1'b0;
  logic               rst_in = 1'b1;
  logic               sample_valid = 1'b0;
  logic               zero_in = 1'b0;
  logic               div_done = 1'b0;
  logic signed [15:0] gx = '0;
  logic signed [15:0] gy = '0;
  logic signed [15:0] gz = '0;
  logic signed [15:0] div_q = '0;
  logic               sample_ready;
  logic               div_start;
  logic signed [15:0] div_a;
  logic signed [15:0] div_b;
  logic signed [15:0] roll;
  logic signed [15:0] pitch;
  logic signed [15:0] yaw;
  logic               ready;
  logic [7:0]         overrun_count;
  logic               div_err;

  gyro_integrate_sched #(.WIDTH(16), .DIVISOR(10), .TIMEOUT(64)) dut (
    .clk_100mhz   (clk_100mhz),
    .rst_in       (rst_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .gx           (gx),
    .gy           (gy),
    .gz           (gz),
    .zero_in      (zero_in),
    .div_start    (div_start),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_done     (div_done),
    .div_q        (div_q),
    .roll         (roll),
    .pitch        (pitch),
    .yaw          (yaw),
    .ready        (ready),
    .overrun_count(overrun_count),
    .div_err      (div_err)
  );

  initial forever #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    int roll;
    int pitch;
    int yaw;
    int cyc;
    int err;
  } exp_t;

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  exp_t  sb[$];
  int    start_cycs[$];
  bit    pending = 0;
  logic signed [15:0] pend_q = '0;
  int    req_idx = 0;
  bit    drop_pitch = 0;

  // Reference model state
  logic signed [15:0] m_acc [3];
  int    m_err = 0;
  int    m_idle = 0;
  int    m_ovr = 0;

  initial forever begin
    @(posedge clk_100mhz);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Divider: latency 1, truncating division by 10; can withhold the pitch quotient.
  initial forever begin
    @(posedge clk_100mhz);
    #1;
    div_done = 1'b0;
    if (pending) begin
      div_done = 1'b1;
      div_q    = pend_q;
      pending  = 0;
    end
    if (rst_in && div_start) begin
      start_cycs.push_back(cyc);
      if (!(drop_pitch && req_idx == 1)) begin
        pending = 1;
        pend_q  = 16'(div_a / 10);
      end
      req_idx = (req_idx + 1) % 3;
    end
  end

  // Model one captured sample whose capture edge is cyc==e. zero_at>=0 means zero_in is
  // high in cycle e+zero_at; axis i accumulates at edge e+2+2i when nothing times out.
  task automatic model_capture(input int e, input logic signed [15:0] s0,
                               input logic signed [15:0] s1, input logic signed [15:0] s2,
                               input int zero_at);
    logic signed [15:0] s [3];
    logic signed [15:0] q;
    int   t;
    bit   drop;
    exp_t x;
    s[0] = s0;
    s[1] = s1;
    s[2] = s2;
    t    = e;
    for (int i = 0; i < 3; i++) begin
      drop = drop_pitch && (i == 1);
      q    = drop ? 16'sd0 : 16'(s[i] / 10);
      if (drop) m_err = 1;
      if (zero_at < 0) m_acc[i] = m_acc[i] + q;
      else if (e + 2 + 2 * i <= e + zero_at + 1) m_acc[i] = 16'sd0;
      else m_acc[i] = q;
      t += 1 + (drop ? 64 : 1);
    end
    x.roll  = m_acc[0];
    x.pitch = m_acc[1];
    x.yaw   = m_acc[2];
    x.cyc   = t;
    x.err   = m_err;
    sb.push_back(x);
    m_idle  = t + 1;
  endtask

  // Hold sample_valid for n cycles; the model decides which cycles capture or overrun.
  task automatic hold(input int n, input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c, input int zero_at);
    gx = a;
    gy = b;
    gz = c;
    sample_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (cyc >= m_idle) model_capture(cyc + 1, a, b, c, zero_at);
      else if (m_ovr < 255) m_ovr++;
      @(posedge clk_100mhz);
      #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c, input int zero_at, output int e);
    while (cyc < m_idle) begin
      @(posedge clk_100mhz);
      #1;
    end
    e = cyc + 1;
    hold(1, a, b, c, zero_at);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk_100mhz);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset(input bit check);
    rst_in       = 1'b0;
    sample_valid = 1'b0;
    zero_in      = 1'b0;
    pending      = 0;
    req_idx      = 0;
    sb.delete();
    start_cycs.delete();
    for (int i = 0; i < 3; i++) m_acc[i] = 16'sd0;
    m_err  = 0;
    m_ovr  = 0;
    m_idle = 0;
    #1;
    if (check) begin
      chk("rst_sample_ready", sample_ready, 1);
      chk("rst_div_start", div_start, 0);
      chk("rst_div_a", div_a, 0);
      chk("rst_roll", roll, 0);
      chk("rst_pitch", pitch, 0);
      chk("rst_yaw", yaw, 0);
      chk("rst_ready", ready, 0);
      chk("rst_overrun", overrun_count, 0);
      chk("rst_div_err", div_err, 0);
      chk("div_b", div_b, 10);
    end
    repeat (2) @(posedge clk_100mhz);
    #1;
    rst_in = 1'b1;
  endtask

  // Monitor: every ready pulse must match the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_100mhz);
      if (rst_in === 1'b1 && ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("roll", roll, x.roll);
          chk("pitch", pitch, x.pitch);
          chk("yaw", yaw, x.yaw);
          chk("ready_cycle", cyc, x.cyc);
          chk("ready_div_err", div_err, x.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    #2;
    do_reset(1);

    // Basic sample and request timing
    send(100, -50, 7, -1, e);
    drain();
    chk("start_count", start_cycs.size(), 3);
    chk("start0_cycle", start_cycs[0], e);
    chk("start1_cycle", start_cycs[1], e + 2);
    chk("start2_cycle", start_cycs[2], e + 4);
    send(100, -50, 7, -1, e);
    send(100, -50, 7, -1, e);
    drain();
    chk("accum_roll", roll, 30);
    chk("accum_pitch", pitch, -15);

    // Wrap-around
    do_reset(0);
    for (int i = 0; i < 11; i++) begin
      send(32767, 0, 0, -1, e);
      if (i == 9) begin
        drain();
        chk("wrap10_roll", roll, 32760);
      end
    end
    drain();
    chk("wrap11_roll", roll, -29500);

    // Overrun and saturation
    do_reset(0);
    hold(20, 40, -40, 3, -1);
    drain();
    chk("overrun20", overrun_count, m_ovr);
    hold(300, 5, 5, 5, -1);
    drain();
    chk("overrun_sat", overrun_count, m_ovr);

    // Divider timeout on pitch; div_err stays set afterwards
    do_reset(0);
    drop_pitch = 1;
    send(100, -50, 7, -1, e);
    drain();
    drop_pitch = 0;
    chk("timeout_err", div_err, 1);
    send(100, -50, 7, -1, e);
    drain();

    // Reset during WAIT of axis 1
    do_reset(0);
    send(100, -50, 7, -1, e);
    drain();
    send(100, -50, 7, -1, e);
    while (cyc < e + 3) begin
      @(posedge clk_100mhz);
      #1;
    end
    #2;
    do_reset(1);
    send(100, -50, 7, -1, e);
    drain();

    // zero_in during ISSUE of axis 1
    do_reset(0);
    send(100, -50, 7, -1, e);
    drain();
    send(200, 300, 400, 2, e);
    while (cyc < e + 2) begin
      @(posedge clk_100mhz);
      #1;
    end
    zero_in = 1'b1;
    @(posedge clk_100mhz);
    #1;
    zero_in = 1'b0;
    chk("zero_roll", roll, 0);
    chk("zero_pitch", pitch, 0);
    chk("zero_yaw", yaw, 0);
    drain();

    // Randomized samples
    do_reset(0);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk_100mhz);
        #1;
      end
      send(16'($urandom), 16'($urandom), 16'($urandom), -1, e);
    end
    drain();
    chk("final_div_err", div_err, 0);
    chk("final_overrun", overrun_count, m_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gyro_integrate_sched.md
# gyro_integrate_sched

Sequencer that time-shares a single external signed divider among the three gyro axes and integrates the scaled rates into roll, pitch and yaw angle registers. It sits between the IMU sample interface and the orientation consumers. It accepts one sample per handshake, issues three divide requests in fixed order (gx→roll, gy→pitch, gz→yaw), and publishes all three angles atomically with a one-cycle `ready` pulse.

## Interface
Parameters:
- `WIDTH`, default 16: sample, quotient and angle width; signed two's complement.
- `DIVISOR`, default 10: constant driven on `div_b`.
- `TIMEOUT`, default 64: maximum WAIT cycles before the divide is abandoned.

Ports:
- `clk_100mhz` in 1: the single clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `sample_valid` in 1: a new gx/gy/gz triple is present.
- `sample_ready` out 1: high only in IDLE; a sample is captured when `sample_valid & sample_ready`.
- `gx`, `gy`, `gz` in WIDTH each: signed angular rates.
- `zero_in` in 1: synchronous clear of the angle accumulators.
- `div_start` out 1: one-cycle request pulse to the divider.
- `div_a` out WIDTH: dividend, held stable from ISSUE until the request completes.
- `div_b` out WIDTH: divisor, constant `DIVISOR`.
- `div_done` in 1: quotient valid this cycle.
- `div_q` in WIDTH: signed quotient.
- `roll`, `pitch`, `yaw` out WIDTH: published angles.
- `ready` out 1: one-cycle pulse; the angles were updated at this edge.
- `overrun_count` out 8: saturating count of dropped samples.
- `div_err` out 1: sticky flag, set on a divide timeout.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. A 2-bit axis index selects the axis: 0=gx/roll, 1=gy/pitch, 2=gz/yaw.
- IDLE:
  - `sample_ready`=1.
  - On handshake, latch gx/gy/gz, set axis=0, go to ISSUE.
- ISSUE:
  - `div_start`=1 for exactly one cycle; `div_a` = latched sample for the current axis.
  - Clear the timeout counter and go to WAIT.
- WAIT, on `div_done`:
  - Add `div_q` to the accumulator for the current axis, wrapping modulo 2^WIDTH with no saturation.
  - If axis<2: axis+1, go to ISSUE. If axis=2: go to DONE.
- WAIT, timeout:
  - If the counter reaches TIMEOUT with no `div_done`, contribute 0 for this axis, set `div_err`, and advance exactly as on done.
- DONE:
  - Copy the three accumulators to `roll`/`pitch`/`yaw` and pulse `ready`.
  - Return to IDLE.
- `div_done` outside WAIT is ignored.
- Overrun:
  - Each cycle with `sample_valid`=1 and `sample_ready`=0 increments `overrun_count`, saturating at 255.
  - That sample is dropped.
- `zero_in`:
  - Clears the accumulators and `roll`/`pitch`/`yaw` to 0 at the next edge.
  - It has priority over a same-cycle accumulate or publish, so that axis's contribution is lost.
  - An in-flight sequence continues and accumulates its remaining axes from 0.
- `div_err` clears only on reset.

## Timing
- Reset values: state IDLE, `sample_ready`=1, `div_start`=0, `div_a`=0, accumulators/`roll`/`pitch`/`yaw`=0, `ready`=0, `overrun_count`=0, `div_err`=0.
- Reset asserted mid-sequence aborts immediately and asynchronously. `div_start` drops with no edge required, and any pending `div_done` is ignored after release.
- Divider latency L≥1: `div_done` is asserted L cycles after the `div_start` cycle.
- Cycle numbering from the capture edge (cycle 0):
  - ISSUE at cycles 1, 2+L, 3+2L.
  - `ready` is high in cycle 4+3L; with L=1 that is cycle 7.
  - `sample_ready` is high again in cycle 5+3L.
- Outputs change only at the DONE edge or on `zero_in`. They never show partial updates.
- Throughput: one sample per 5+3L cycles.

## Test plan
- Behavioural divider for all tests: truncates toward zero, L=1, DIVISOR=10.
- Basic sample: gx=100, gy=-50, gz=7, single handshake → roll=10, pitch=-5, yaw=0; `ready` high exactly in cycle 7; three `div_start` pulses in cycles 1, 3, 5.
- Accumulation: the same sample three times → roll=30, pitch=-15, yaw=0; three `ready` pulses.
- Wrap: gx=32767 eleven times → roll=32760 after 10 samples, then -29500 after the 11th.
- Overrun: `sample_valid` held high for 20 cycles → one capture, ready at cycle 7, second capture in cycle 8, `overrun_count` increments in each cycle `sample_ready`=0.
- Timeout: divider never asserts done for the pitch request → after 64 WAIT cycles `div_err`=1, pitch unchanged, roll/yaw updated, `ready` pulses.
- Reset/zero: assert `rst_in`=0 during WAIT of axis 1 → all outputs reset immediately, IDLE after release. Separately, `zero_in` pulse mid-sequence → the final angles contain only the axes accumulated after the clear.
